// File: rtl/prog_tick_divider.sv
// prog_tick_divider: multi-channel run-time programmable divider / tick generator.
// Ports: clk, reset_n, en/clr per channel, cfg valid/ready divisor port, tick/clk_out per channel.
module prog_tick_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DIV_DEFAULT = 100_000_000,
    parameter int CASCADE     = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic              ch_ok;
    logic              xfer;
    logic              bad;
    logic              wr_ok;
    logic [7:0]        pend_pad;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] at_end;
    logic [NUM_CH-1:0] advance;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channels stay ready so the rejection can complete.
    assign ch_ok     = {1'b0, cfg_ch} < 4'(NUM_CH);
    assign pend_pad  = 8'(pend);
    assign cfg_ready = ch_ok ? ~pend_pad[cfg_ch] : 1'b1;
    assign xfer      = cfg_valid & cfg_ready;
    assign bad       = ~ch_ok | (cfg_div == '0);
    assign wr_ok     = xfer & ~bad;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            wr_sel[k] = wr_ok & (cfg_ch == 3'(k));
        end
    end

    // Cascade chain: a channel only advances on its predecessor's wrap,
    // so coincident wraps ripple through in the same cycle.
    always_comb begin
        logic chain;
        logic a;
        chain = 1'b1;
        a     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            a = en[k] & ~clr[k];
            if (CASCADE != 0) begin
                a = a & chain;
            end
            advance[k] = a;
            wrap[k]    = a & at_end[k];
            chain      = a & at_end[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= xfer & bad;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] pdiv;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] phalf;
        logic [CNT_W-1:0] cnt_inc;
        logic             pnd;
        logic             tck;
        logic             sq;

        assign half       = div >> 1;
        assign phalf      = pdiv >> 1;
        assign cnt_inc    = cnt + ONE;
        assign at_end[k]  = (cnt == div - ONE);
        assign pend[k]    = pnd;
        assign tick[k]    = tck;
        assign clk_out[k] = sq;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= '0;
                div  <= DIV_RST;
                pdiv <= '0;
                pnd  <= 1'b0;
                tck  <= 1'b0;
                sq   <= 1'b0;
            end else if (clr[k]) begin
                // Phase clear wins over en and wrap; a parked divisor
                // takes effect right away.
                cnt <= '0;
                tck <= 1'b0;
                sq  <= 1'b0;
                if (pnd) begin
                    div <= pdiv;
                    pnd <= 1'b0;
                end else if (wr_sel[k]) begin
                    div <= cfg_div;
                end
            end else if (!advance[k]) begin
                tck <= 1'b0;
                if (wr_sel[k]) begin
                    div <= cfg_div;
                    cnt <= '0;
                end
            end else begin
                tck <= wrap[k];
                if (wrap[k]) begin
                    cnt <= '0;
                    if (pnd) begin
                        div <= pdiv;
                        pnd <= 1'b0;
                        sq  <= (phalf != '0);
                    end else begin
                        sq  <= (half != '0);
                    end
                end else begin
                    cnt <= cnt_inc;
                    sq  <= (cnt_inc < half);
                end
                // A write to a running channel is parked until the
                // current period ends, so no short or long pulse appears.
                if (wr_sel[k]) begin
                    pdiv <= cfg_div;
                    pnd  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_tick_divider.sv
// tb_prog_tick_divider: directed and randomized checks of prog_tick_divider.
// Two instances: independent channels (u_ind) and cascaded channels (u_cas).
module tb_prog_tick_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  en_a   [2];
    logic [3:0]  clr_a  [2];
    logic        cv_a   [2];
    logic [2:0]  ch_a   [2];
    logic [31:0] dv_a   [2];
    logic        rdy_o  [2];
    logic        err_o  [2];
    logic [3:0]  tick_o [2];
    logic [3:0]  ck_o   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_tick_divider #(
        .NUM_CH(4), .CNT_W(32), .DIV_DEFAULT(4), .CASCADE(0)
    ) u_ind (
        .clk(clk), .reset_n(reset_n),
        .en(en_a[0]), .clr(clr_a[0]),
        .cfg_valid(cv_a[0]), .cfg_ready(rdy_o[0]),
        .cfg_ch(ch_a[0]), .cfg_div(dv_a[0]),
        .cfg_err(err_o[0]), .tick(tick_o[0]), .clk_out(ck_o[0])
    );

    prog_tick_divider #(
        .NUM_CH(4), .CNT_W(32), .DIV_DEFAULT(4), .CASCADE(1)
    ) u_cas (
        .clk(clk), .reset_n(reset_n),
        .en(en_a[1]), .clr(clr_a[1]),
        .cfg_valid(cv_a[1]), .cfg_ready(rdy_o[1]),
        .cfg_ch(ch_a[1]), .cfg_div(dv_a[1]),
        .cfg_err(err_o[1]), .tick(tick_o[1]), .clk_out(ck_o[1])
    );

    // Reference model: each channel is a phase within a period; the
    // square wave is high while phase < period/2.
    int unsigned m_phase [2][4];
    int unsigned m_per   [2][4];
    int unsigned m_next  [2][4];
    bit          m_has   [2][4];
    bit          m_tick  [2][4];
    bit          m_sq    [2][4];
    bit          m_err   [2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_err[d] = 0;
                for (int k = 0; k < 4; k++) begin
                    m_phase[d][k] = 0;
                    m_per[d][k]   = 4;
                    m_next[d][k]  = 0;
                    m_has[d][k]   = 0;
                    m_tick[d][k]  = 0;
                    m_sq[d][k]    = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit ok, acc, good, carry, run, wrapped, wr;
                ok    = ch_a[d] < 3'd4;
                acc   = cv_a[d] && (!ok || !m_has[d][ch_a[d][1:0]]);
                good  = ok && dv_a[d] != 0;
                m_err[d] = acc && !good;
                carry = 1;
                for (int k = 0; k < 4; k++) begin
                    run = en_a[d][k] && !clr_a[d][k] && (d == 0 || carry);
                    wrapped = run && (m_phase[d][k] + 1 == m_per[d][k]);
                    carry = wrapped;
                    wr = acc && good && (int'(ch_a[d]) == k);
                    if (clr_a[d][k]) begin
                        m_phase[d][k] = 0;
                        m_tick[d][k]  = 0;
                        m_sq[d][k]    = 0;
                        if (m_has[d][k]) begin
                            m_per[d][k] = m_next[d][k];
                            m_has[d][k] = 0;
                        end else if (wr) begin
                            m_per[d][k] = dv_a[d];
                        end
                    end else if (!run) begin
                        m_tick[d][k] = 0;
                        if (wr) begin
                            m_per[d][k]   = dv_a[d];
                            m_phase[d][k] = 0;
                        end
                    end else begin
                        m_tick[d][k] = wrapped;
                        if (wrapped) begin
                            m_phase[d][k] = 0;
                            if (m_has[d][k]) begin
                                m_per[d][k] = m_next[d][k];
                                m_has[d][k] = 0;
                            end
                        end else begin
                            m_phase[d][k] = m_phase[d][k] + 1;
                        end
                        m_sq[d][k] = m_phase[d][k] < m_per[d][k] / 2;
                        if (wr) begin
                            m_next[d][k] = dv_a[d];
                            m_has[d][k]  = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [3:0] mtick(input int d);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = m_tick[d][k];
        return r;
    endfunction

    function automatic logic [3:0] mclk(input int d);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = m_sq[d][k];
        return r;
    endfunction

    function automatic logic mready(input int d);
        if (ch_a[d] >= 3'd4) return 1'b1;
        return !m_has[d][ch_a[d][1:0]];
    endfunction

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            en_a[d]  = '0;
            clr_a[d] = '0;
            cv_a[d]  = 1'b0;
            ch_a[d]  = '0;
            dv_a[d]  = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tick_o[d] !== 4'b0) begin
                errors++;
                $display("FAIL reset_tick d%0d got %b want 0000", d, tick_o[d]);
            end
            checks++;
            if (ck_o[d] !== 4'b0) begin
                errors++;
                $display("FAIL reset_clk d%0d got %b want 0000", d, ck_o[d]);
            end
            checks++;
            if (err_o[d] !== 1'b0 || rdy_o[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_cfg d%0d got err=%b rdy=%b want 0 1",
                         d, err_o[d], rdy_o[d]);
            end
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_default_div();
        en_a[0] = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tick_o[0][0] !== (n % 4 == 0)) begin
                errors++;
                $display("FAIL def_tick n=%0d got %b want %b",
                         n, tick_o[0][0], n % 4 == 0);
            end
            checks++;
            if (ck_o[0][0] !== (n % 4 <= 1)) begin
                errors++;
                $display("FAIL def_clk n=%0d got %b want %b",
                         n, ck_o[0][0], n % 4 <= 1);
            end
        end
    endtask

    task automatic test_cfg_idle();
        en_a[0] = 4'b0000;
        cv_a[0] = 1'b1;
        ch_a[0] = 3'd0;
        dv_a[0] = 32'd5;
        #1;
        checks++;
        if (rdy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_rdy got %b want 1", rdy_o[0]);
        end
        @(posedge clk);
        #1;
        cv_a[0] = 1'b0;
        en_a[0] = 4'b0001;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tick_o[0][0] !== (n % 5 == 0)) begin
                errors++;
                $display("FAIL div5_tick n=%0d got %b want %b",
                         n, tick_o[0][0], n % 5 == 0);
            end
            checks++;
            if (ck_o[0][0] !== (n % 5 <= 1)) begin
                errors++;
                $display("FAIL div5_clk n=%0d got %b want %b",
                         n, ck_o[0][0], n % 5 <= 1);
            end
        end
    endtask

    task automatic test_pending();
        do_reset();
        cv_a[0] = 1'b1;
        ch_a[0] = 3'd0;
        dv_a[0] = 32'd8;
        @(posedge clk);
        #1;
        cv_a[0] = 1'b0;
        en_a[0] = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        cv_a[0] = 1'b1;
        dv_a[0] = 32'd3;
        #1;
        checks++;
        if (rdy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL pend_rdy0 got %b want 1", rdy_o[0]);
        end
        for (int n = 3; n <= 17; n++) begin
            @(posedge clk);
            #1;
            cv_a[0] = 1'b0;
            checks++;
            if (tick_o[0][0] !== (n == 8 || n == 11 || n == 14 || n == 17)) begin
                errors++;
                $display("FAIL pend_tick n=%0d got %b", n, tick_o[0][0]);
            end
            #1;
            checks++;
            if (rdy_o[0] !== (n >= 8)) begin
                errors++;
                $display("FAIL pend_rdy n=%0d got %b want %b",
                         n, rdy_o[0], n >= 8);
            end
        end
    endtask

    task automatic test_reject();
        for (int n = 18; n <= 24; n++) begin
            cv_a[0] = (n == 18 || n == 20);
            ch_a[0] = (n == 20) ? 3'd7 : 3'd1;
            dv_a[0] = (n == 20) ? 32'd9 : 32'd0;
            #1;
            if (cv_a[0]) begin
                checks++;
                if (rdy_o[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rej_rdy n=%0d got %b want 1", n, rdy_o[0]);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (err_o[0] !== (n == 18 || n == 20)) begin
                errors++;
                $display("FAIL rej_err n=%0d got %b", n, err_o[0]);
            end
            checks++;
            if (tick_o[0][0] !== (n % 3 == 2)) begin
                errors++;
                $display("FAIL rej_tick n=%0d got %b want %b",
                         n, tick_o[0][0], n % 3 == 2);
            end
        end
        cv_a[0] = 1'b0;
    endtask

    task automatic test_cascade();
        do_reset();
        cv_a[1] = 1'b1;
        ch_a[1] = 3'd0;
        dv_a[1] = 32'd10;
        @(posedge clk);
        #1;
        ch_a[1] = 3'd1;
        dv_a[1] = 32'd6;
        @(posedge clk);
        #1;
        cv_a[1] = 1'b0;
        en_a[1] = 4'b0011;
        for (int n = 1; n <= 125; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tick_o[1][1:0] !== {n % 60 == 0, n % 10 == 0}) begin
                errors++;
                $display("FAIL casc_tick n=%0d got %b", n, tick_o[1][1:0]);
            end
        end
    endtask

    task automatic test_clr_pending();
        do_reset();
        cv_a[0] = 1'b1;
        ch_a[0] = 3'd0;
        dv_a[0] = 32'd8;
        @(posedge clk);
        #1;
        cv_a[0] = 1'b0;
        en_a[0] = 4'b0001;
        @(posedge clk);
        #1;
        cv_a[0] = 1'b1;
        dv_a[0] = 32'd5;
        @(posedge clk);
        #1;
        cv_a[0] = 1'b0;
        @(posedge clk);
        #1;
        clr_a[0] = 4'b0001;
        #1;
        checks++;
        if (rdy_o[0] !== 1'b0 || ck_o[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre got rdy=%b clk=%b want 0 1",
                     rdy_o[0], ck_o[0][0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tick_o[0][0] !== 1'b0 || ck_o[0][0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_post got tick=%b clk=%b rdy=%b want 0 0 1",
                     tick_o[0][0], ck_o[0][0], rdy_o[0]);
        end
        clr_a[0] = 4'b0000;
        for (int m = 1; m <= 10; m++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tick_o[0][0] !== (m % 5 == 0) || ck_o[0][0] !== (m % 5 <= 1)) begin
                errors++;
                $display("FAIL clr_run m=%0d got tick=%b clk=%b", m,
                         tick_o[0][0], ck_o[0][0]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en_a[0] = 4'b1111;
        en_a[1] = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        cv_a[0] = 1'b1;
        ch_a[0] = 3'd2;
        dv_a[0] = 32'd7;
        @(posedge clk);
        #1;
        cv_a[0] = 1'b0;
        checks++;
        if (rdy_o[0] !== 1'b0 || ck_o[0] !== 4'b1111) begin
            errors++;
            $display("FAIL ares_pre got rdy=%b clk=%b want 0 1111",
                     rdy_o[0], ck_o[0]);
        end
        #3 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tick_o[d] !== 4'b0 || ck_o[d] !== 4'b0) begin
                errors++;
                $display("FAIL ares_out d%0d got tick=%b clk=%b want 0",
                         d, tick_o[d], ck_o[d]);
            end
            checks++;
            if (rdy_o[d] !== 1'b1 || err_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL ares_cfg d%0d got rdy=%b err=%b want 1 0",
                         d, rdy_o[d], err_o[d]);
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (tick_o[d] !== mtick(d)) begin
                    errors++;
                    $display("FAIL rnd_tick c=%0d d%0d got %b want %b",
                             c, d, tick_o[d], mtick(d));
                end
                checks++;
                if (ck_o[d] !== mclk(d)) begin
                    errors++;
                    $display("FAIL rnd_clk c=%0d d%0d got %b want %b",
                             c, d, ck_o[d], mclk(d));
                end
                checks++;
                if (err_o[d] !== m_err[d]) begin
                    errors++;
                    $display("FAIL rnd_err c=%0d d%0d got %b want %b",
                             c, d, err_o[d], m_err[d]);
                end
                for (int k = 0; k < 4; k++) begin
                    en_a[d][k]  = ($urandom_range(0, 7) != 0);
                    clr_a[d][k] = ($urandom_range(0, 31) == 0);
                end
                cv_a[d] = ($urandom_range(0, 3) == 0);
                ch_a[d] = ($urandom_range(0, 7) == 0)
                          ? 3'($urandom_range(4, 7))
                          : 3'($urandom_range(0, 3));
                dv_a[d] = ($urandom_range(0, 9) == 0)
                          ? 32'd0 : 32'($urandom_range(1, 12));
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy_o[d] !== mready(d)) begin
                    errors++;
                    $display("FAIL rnd_rdy c=%0d d%0d got %b want %b",
                             c, d, rdy_o[d], mready(d));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_cfg_idle();
        test_pending();
        test_reject();
        test_cascade();
        test_clr_pending();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_tick_divider.md
# prog_tick_divider

Multi-channel, run-time programmable clock divider and tick generator. It supersedes the fixed 100 MHz→1 Hz toggle divider. Each of NUM_CH channels divides the system clock, or the previous channel's tick in cascade mode, by a 32-bit divisor loaded through a valid/ready port. Every channel drives a one-cycle tick strobe and a near-50 % square wave. It sits beside the oven controller and feeds timer countdown, display blink, and buzzer cadence.

## Interface
- NUM_CH, 4, number of divider channels (1..8)
- CNT_W, 32, counter and divisor width
- DIV_DEFAULT, 100_000_000, divisor loaded into every channel at reset
- CASCADE, 0, 0 = all channels count clk; 1 = channel k>0 advances only on channel k-1 wrap
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable (level)
- clr  in  NUM_CH  per-channel synchronous phase clear (level, sampled each cycle)
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write can be accepted for channel cfg_ch
- cfg_ch  in  3  target channel index
- cfg_div  in  CNT_W  new divisor
- cfg_err  out  1  one-cycle pulse when a write was rejected
- tick  out  NUM_CH  one-cycle strobe, once per divisor period
- clk_out  out  NUM_CH  square wave, period = divisor

## Operation
- Per channel: cnt[CNT_W], div[CNT_W], pend (1 bit), pdiv[CNT_W].
- advance[k] = en[k] & ~clr[k], additionally ANDed with wrap[k-1] when CASCADE=1 and k>0.
- wrap[k] = advance[k] & (cnt == div-1). This is the internal combinational strobe.
- On advance: cnt ← wrap ? 0 : cnt+1. tick[k] ← wrap[k], registered. Otherwise tick[k] ← 0.
- clk_out[k] ← (next cnt < div>>1). The register holds its value while not advancing.
  - div=1: tick every advancing cycle, clk_out held 0.
  - Odd div: high for (div-1)/2 cycles, low for the rest.
- clr[k]: cnt ← 0, tick ← 0, clk_out ← 0. Any pending divisor is applied immediately. clr has priority over en and over wrap.
- Handshake: cfg_ready = ~pend[cfg_ch] while cfg_ch < NUM_CH. When cfg_ch ≥ NUM_CH, cfg_ready = 1 so the error can complete. A transfer occurs on a cycle with cfg_valid & cfg_ready.
- Rejection: cfg_div == 0 or cfg_ch ≥ NUM_CH. cfg_err is pulsed the next cycle and no state changes.
- Accepted write, channel not advancing in that cycle (en=0 or clr=1): div ← cfg_div and cnt ← 0 on the same edge. No pend.
- Accepted write, channel advancing: pdiv ← cfg_div, pend ← 1. On the edge of the next wrap, div ← pdiv, pend ← 0, cnt ← 0. The current period always completes with the old divisor, so there is no glitch.
- Accepted write on the same cycle as a wrap: the write goes to pend. It takes effect at the following wrap.
- Cascade: ticks of channels 0..k occur in the same cycle when they coincide.

## Timing
- Reset values (reset_n low, asynchronous): cnt=0, div=DIV_DEFAULT, pend=0, tick=0, clk_out=0, cfg_err=0. cfg_ready=1.
- en high from the first edge after reset release: the first tick asserts after edge div. Ticks follow exactly every div cycles.
- tick and clk_out are registered, with one edge of latency from the wrap condition.
- cfg_ready is combinational from pend and cfg_ch. No other combinational input→output paths.
- Dropping en freezes cnt, clk_out, and pending state. tick returns to 0 on the next edge. Re-enabling resumes the count.
- reset_n asserted mid-period clears everything immediately, including pending writes.

## Test plan
- Reset, DIV_DEFAULT=4, en=1 on channel 0 → tick[0] high for 1 cycle at cycles 4, 8, 12. clk_out[0] pattern: high 2 cycles, low 2 cycles after the first period.
- div=5 via cfg while en=0 → cfg_ready=1, write accepted. Then en=1 → ticks every 5 cycles, clk_out high 2 cycles, low 3 cycles.
- Running div=8, write div=3 at cnt=2 → cfg_ready low until the wrap. The next tick is 6 cycles later (old period). The subsequent ticks are every 3 cycles.
- cfg_div=0 and, separately, cfg_ch=7 with NUM_CH=4 → cfg_err pulses once each. Divisors and ticks are unchanged.
- CASCADE=1, div0=10, div1=6 → tick[1] every 60 cycles, coincident with every 6th tick[0].
- clr[0] asserted at cnt=3 with a pending write → cnt=0 and new divisor active immediately. Deassert reset_n mid-period → all outputs 0 asynchronously and cfg_ready=1.
